hazard_stall_ctrl: RTL and testbench

//  Producer-side hazard controller paired with the EX-stage forwarding unit.

---
 rtl/hazard_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use bubble insertion and memory-wait pipeline freeze controller.
// Define HAZARD_STALL_CNT_EN to build the saturating stall performance counters.
module hazard_stall_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs1_addr_id,
  input  logic [ADDR_W-1:0] rs2_addr_id,
  input  logic              memread_exe,
  input  logic [ADDR_W-1:0] rd_addr_exe,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              freeze,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t              state_q;
  logic [WCNT_W-1:0]   wait_cnt_q;
  logic                mem_timeout_q;
  logic                freeze_d;
  logic                load_use_d;

  always_comb begin
    freeze_d = 1'b0;
    unique case (state_q)
      IDLE:    freeze_d = mem_req & ~mem_ack;
      WAIT:    freeze_d = ~mem_ack;
      ERROR:   freeze_d = 1'b1;
      default: freeze_d = 1'b0;
    endcase
  end

  // x0 is hardwired to zero, so a load targeting it can never be a hazard.
  assign load_use_d = memread_exe && (rd_addr_exe != '0) &&
                      ((rd_addr_exe == rs1_addr_id) || (rd_addr_exe == rs2_addr_id));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    if (!rst_i) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (freeze_d) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      freeze      = 1'b1;
    end else if (load_use_d) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_req && !mem_ack) begin
            state_q    <= WAIT;
            wait_cnt_q <= WCNT_W'(1);
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state_q <= IDLE;
          end else if (wait_cnt_q == WCNT_W'(MAX_WAIT)) begin
            state_q       <= ERROR;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
          end
        end
        ERROR:   state_q <= ERROR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] mem_cnt_q;

  // Outputs already reflect reset, so only active cycles reach the counters.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (idex_bubble && (lu_cnt_q != '1))
        lu_cnt_q <= lu_cnt_q + CNT_W'(1);
      if (freeze && (mem_cnt_q != '1))
        mem_cnt_q <= mem_cnt_q + CNT_W'(1);
    end
  end

  assign lu_stall_cnt  = lu_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;
`else
  assign lu_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed per-cycle vectors feeding a scoreboard queue; a negedge monitor checks outputs.
module tb_hazard_stall_ctrl;

  localparam int ADDR_W = 5;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W = 3;

  // {pc_write, ifid_write, idex_bubble, freeze}
  localparam logic [3:0] NRM = 4'b1100;
  localparam logic [3:0] BUB = 4'b0010;
  localparam logic [3:0] FRZ = 4'b0001;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [ADDR_W-1:0] rs1_addr_id, rs2_addr_id, rd_addr_exe;
  logic              memread_exe, mem_req, mem_ack;
  logic              pc_write, ifid_write, idex_bubble, freeze, mem_timeout;
  logic [CNT_W-1:0]  lu_stall_cnt, mem_stall_cnt;

  typedef struct packed {
    logic [3:0]       outs;
    logic             tmo;
    logic [CNT_W-1:0] lu;
    logic [CNT_W-1:0] mem;
    logic [15:0]      id;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  hazard_stall_ctrl #(
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rs1_addr_id  (rs1_addr_id),
    .rs2_addr_id  (rs2_addr_id),
    .memread_exe  (memread_exe),
    .rd_addr_exe  (rd_addr_exe),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .freeze       (freeze),
    .mem_timeout  (mem_timeout),
    .lu_stall_cnt (lu_stall_cnt),
    .mem_stall_cnt(mem_stall_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                      input logic mr, input logic [4:0] rd, input logic rq, input logic ak,
                      input logic [3:0] o, input logic t, input int l, input int m);
    exp_t x;
    @(posedge clk_i);
    #1;
    rst_i = r; rs1_addr_id = a1; rs2_addr_id = a2;
    memread_exe = mr; rd_addr_exe = rd; mem_req = rq; mem_ack = ak;
    x.outs = o;
    x.tmo  = t;
`ifdef HAZARD_STALL_CNT_EN
    x.lu  = CNT_W'(l);
    x.mem = CNT_W'(m);
`else
    x.lu  = '0;
    x.mem = '0;
`endif
    x.id = 16'(cyc);
    cyc++;
    exp_q.push_back(x);
  endtask

  // Monitor: compare whenever a vector is pending, half a cycle after it was applied.
  initial begin
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({pc_write, ifid_write, idex_bubble, freeze} !== e.outs) begin
          n_errors++;
          $display("FAIL stall_outs c%0d got=%b want=%b", e.id,
                   {pc_write, ifid_write, idex_bubble, freeze}, e.outs);
        end
        n_checks++;
        if (mem_timeout !== e.tmo) begin
          n_errors++;
          $display("FAIL mem_timeout c%0d got=%b want=%b", e.id, mem_timeout, e.tmo);
        end
        n_checks++;
        if ({lu_stall_cnt, mem_stall_cnt} !== {e.lu, e.mem}) begin
          n_errors++;
          $display("FAIL counters c%0d got lu=%0d mem=%0d want lu=%0d mem=%0d", e.id,
                   lu_stall_cnt, mem_stall_cnt, e.lu, e.mem);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b0; rs1_addr_id = '0; rs2_addr_id = '0; rd_addr_exe = '0;
    memread_exe = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk_i);
    //    rst rs1 rs2 mr rd req ack  outs tmo lu mem
    step(0,  5,  0, 1, 5, 1, 0,  BUB, 0, 0, 0);  // c0 reset overrides inputs
    step(1,  0,  0, 0, 0, 0, 0,  NRM, 0, 0, 0);  // c1
    step(1,  5,  6, 1, 5, 0, 0,  BUB, 0, 0, 0);  // c2 load-use on rs1
    step(1,  1,  2, 0, 0, 0, 0,  NRM, 0, 1, 0);  // c3
    step(1,  3,  7, 1, 7, 0, 0,  BUB, 0, 1, 0);  // c4 load-use on rs2
    step(1,  8,  9, 0, 0, 0, 0,  NRM, 0, 2, 0);  // c5
    step(1,  0,  0, 1, 0, 0, 0,  NRM, 0, 2, 0);  // c6 x0 never hazards
    step(1,  5,  0, 0, 5, 0, 0,  NRM, 0, 2, 0);  // c7 not a load
    step(1,  0,  0, 0, 0, 1, 1,  NRM, 0, 2, 0);  // c8 same-cycle ack
    step(1,  0,  0, 0, 0, 0, 0,  NRM, 0, 2, 0);  // c9 still IDLE
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 2, 0);  // c10 three-cycle wait
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 2, 1);  // c11
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 2, 2);  // c12
    step(1,  0,  0, 0, 0, 1, 1,  NRM, 0, 2, 3);  // c13 ack releases
    step(1,  0,  0, 0, 0, 0, 0,  NRM, 0, 2, 3);  // c14
    step(1,  9,  1, 1, 9, 1, 0,  FRZ, 0, 2, 3);  // c15 pair held while frozen
    step(1,  9,  1, 1, 9, 1, 0,  FRZ, 0, 2, 4);  // c16
    step(1,  9,  1, 1, 9, 1, 1,  BUB, 0, 2, 5);  // c17 first unfrozen cycle
    step(1,  2,  3, 0, 0, 0, 0,  NRM, 0, 3, 5);  // c18
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 3, 5);  // c19 timeout sequence
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 3, 6);  // c20
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 3, 7);  // c21 counter saturates
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 3, 7);  // c22
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 3, 7);  // c23 wait_cnt==MAX_WAIT
    step(1,  3,  0, 1, 3, 0, 1,  FRZ, 1, 3, 7);  // c24 ERROR ignores ack/load-use
    step(1,  0,  0, 0, 0, 0, 0,  FRZ, 1, 3, 7);  // c25
    step(0,  0,  0, 0, 0, 1, 0,  BUB, 1, 3, 7);  // c26 reset out of ERROR
    step(1,  0,  0, 0, 0, 0, 0,  NRM, 0, 0, 0);  // c27
    step(1,  0,  0, 0, 0, 1, 0,  FRZ, 0, 0, 0);  // c28 enter WAIT
    step(0,  0,  0, 0, 0, 1, 0,  BUB, 0, 0, 1);  // c29 reset mid-WAIT
    step(1,  0,  0, 0, 0, 0, 0,  NRM, 0, 0, 0);  // c30 request abandoned
    for (int i = 0; i < 8; i++)
      step(1, 4, 0, 1, 4, 0, 0,  BUB, 0, i, 0);  // c31-c38 bubble counter ramp
    step(1,  0,  0, 0, 0, 0, 0,  NRM, 0, 7, 0);  // c39 saturated, no wrap
    step(1,  0,  0, 0, 0, 0, 0,  NRM, 0, 7, 0);  // c40
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
    @(posedge clk_i);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
